// File: rtl/det_logger_pkg.sv
// det_logger_pkg: shared FSM state type and default parameters for the detection logger
package det_logger_pkg;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_TSW   = 8;
    localparam int DEF_CNTW  = 16;
    typedef enum logic {LOW = 1'b0, HIGH = 1'b1} state_t;
endpackage

// File: rtl/det_fifo.sv
// det_fifo: power-of-two circular FIFO with level count and synchronous flush
module det_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          do_push, do_pop;
    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr];
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wptr] <= din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            level <= (do_push && !do_pop) ? level + 1'b1 :
                     (!do_push && do_pop) ? level - 1'b1 : level;
        end
    end
endmodule

// File: rtl/det_logger.sv
// det_logger: rising-edge detection logger that timestamps qualified det edges into a FIFO
module det_logger
    import det_logger_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int TSW   = DEF_TSW,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     det,
    input  logic                     clr,
    output logic                     ev_valid,
    input  logic                     ev_ready,
    output logic [TSW-1:0]           ev_ts,
    output logic [CNTW-1:0]          det_cnt,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   level
);
    logic [TSW-1:0] ts;
    state_t         state;
    logic           ev, pop, full, empty;
    assign ev       = in_valid & det & (state == LOW);
    assign pop      = ev_valid & ev_ready;
    assign ev_valid = ~empty;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else ts <= ts + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOW;
        else if (clr) state <= LOW;
        else if (in_valid) state <= det ? HIGH : LOW;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_cnt <= '0;
            ovf     <= 1'b0;
        end else if (clr) begin
            det_cnt <= '0;
            ovf     <= 1'b0;
        end else begin
            if (ev && det_cnt != '1) det_cnt <= det_cnt + 1'b1;
            if (ev && full && !pop) ovf <= 1'b1;
        end
    end
    det_fifo #(.DEPTH(DEPTH), .W(TSW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (ev & ~clr),
        .pop   (pop & ~clr),
        .din   (ts),
        .dout  (ev_ts),
        .full  (full),
        .empty (empty),
        .level (level)
    );
endmodule
